// File: rtl/instr_player_if.sv
// Host/core-facing bundle for instr_player: program load channel, playback
// control, instruction stream and status.
interface instr_player_if #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 16
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                 load_valid_i;
  logic [DATAWIDTH-1:0] load_data_i;
  logic                 load_ready_o;
  logic                 load_clear_i;
  logic                 start_i;
  logic                 mode_i;
  logic                 stop_i;
  logic [DATAWIDTH-1:0] instr_o;
  logic                 instr_valid_o;
  logic                 instr_ready_i;
  logic                 busy_o;
  logic                 done_o;
  logic [CW-1:0]        count_o;
  logic [PW-1:0]        pc_o;
  logic [15:0]          loops_o;

  // The player itself.
  modport slave (
    input  load_valid_i, load_data_i, load_clear_i, start_i, mode_i, stop_i,
           instr_ready_i,
    output load_ready_o, instr_o, instr_valid_o, busy_o, done_o, count_o,
           pc_o, loops_o
  );

  // Whoever loads the program and consumes the instruction stream.
  modport master (
    output load_valid_i, load_data_i, load_clear_i, start_i, mode_i, stop_i,
           instr_ready_i,
    input  load_ready_o, instr_o, instr_valid_o, busy_o, done_o, count_o,
           pc_o, loops_o
  );
endinterface

// File: rtl/instr_player.sv
// Instruction player: stores a small program, then replays it word by word to
// a core over a valid/ready stream, once or in a loop, until HALT/stop/end.
module instr_player #(
  parameter int          DATAWIDTH = 32,
  parameter int          DEPTH     = 16,
  parameter logic [3:0]  HALT_OP   = 4'hF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  instr_player_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        pc_q, pc_d;
  logic [15:0]          loops_q, loops_d;
  logic                 mode_q, mode_d;
  logic                 done_q, done_d;
  logic [DATAWIDTH-1:0] instr_q, instr_d;

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic                 wr_en;
  logic [PW-1:0]        wr_addr;
  logic                 load_ready;
  logic                 xfer;
  logic                 last_word;
  logic                 is_halt;

  assign load_ready = (state_q == IDLE) && (count_q < CW'(DEPTH));
  assign xfer       = (state_q == RUN) && bus.instr_ready_i;
  assign last_word  = ({1'b0, pc_q} == (count_q - CW'(1)));
  assign is_halt    = (instr_q[3:0] == HALT_OP);
  assign wr_addr    = count_q[PW-1:0];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pc_d    = pc_q;
    loops_d = loops_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_clear_i) begin
          count_d = '0;
        end else begin
          if (bus.load_valid_i && load_ready) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
          end
          // Start qualifies on the pre-load count; a word arriving alongside is still played.
          if (bus.start_i && (count_q != '0)) begin
            state_d = RUN;
            pc_d    = '0;
            loops_d = '0;
            mode_d  = bus.mode_i;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          if (last_word && mode_q) loops_d = loops_q + 16'd1;
          if (is_halt || bus.stop_i || (last_word && !mode_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (last_word) begin
            pc_d = '0;
          end else begin
            pc_d = pc_q + PW'(1);
          end
        end else if (bus.stop_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // No writes happen in RUN, so re-reading mem[pc] during a stall yields the held word.
    instr_d = (state_d == RUN) ? mem[pc_d] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= bus.load_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      pc_q    <= '0;
      loops_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      loops_q <= loops_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      instr_q <= instr_d;
    end
  end

  assign bus.load_ready_o  = load_ready;
  assign bus.instr_o       = instr_q;
  assign bus.instr_valid_o = (state_q == RUN);
  assign bus.busy_o        = (state_q == RUN);
  assign bus.done_o        = done_q;
  assign bus.count_o       = count_q;
  assign bus.pc_o          = pc_q;
  assign bus.loops_o       = loops_q;
endmodule

// File: tb/tb_instr_player.sv
// Self-checking bench for instr_player: directed scenarios plus random traffic,
// checked every cycle against a delivered-word-count model of playback.
module tb_instr_player;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_player_if #(.DATAWIDTH(DW), .DEPTH(DEPTH)) bus ();

  instr_player #(.DATAWIDTH(DW), .DEPTH(DEPTH), .HALT_OP(4'hF)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: playback position is derived from the number of words delivered since start.
  logic [DW-1:0] m_prog [DEPTH];
  int            m_cnt;
  int            m_run_cnt;
  int            m_n;
  int            m_hold_pc;
  bit            m_run;
  bit            m_mode;
  bit            m_done;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_pc();
    return m_run ? (m_n % m_run_cnt) : m_hold_pc;
  endfunction

  function automatic int m_loops();
    return m_mode ? ((m_n / m_run_cnt) & 16'hFFFF) : 0;
  endfunction

  task automatic model_reset();
    m_cnt     = 0;
    m_run_cnt = 1;
    m_n       = 0;
    m_hold_pc = 0;
    m_run     = 1'b0;
    m_mode    = 1'b0;
    m_done    = 1'b0;
  endtask

  task automatic check_outputs();
    check_eq("busy",  64'(bus.busy_o),        64'(m_run));
    check_eq("valid", 64'(bus.instr_valid_o), 64'(m_run));
    check_eq("instr", 64'(bus.instr_o),       m_run ? 64'(m_prog[m_pc()]) : 64'd0);
    check_eq("pc",    64'(bus.pc_o),          64'(m_pc()));
    check_eq("count", 64'(bus.count_o),       64'(m_cnt));
    check_eq("loops", 64'(bus.loops_o),       64'(m_loops()));
    check_eq("done",  64'(bus.done_o),        64'(m_done));
    check_eq("lready", 64'(bus.load_ready_o), 64'(!m_run && (m_cnt < DEPTH)));
  endtask

  task automatic drive_idle();
    bus.load_valid_i  = 1'b0;
    bus.load_data_i   = '0;
    bus.load_clear_i  = 1'b0;
    bus.start_i       = 1'b0;
    bus.mode_i        = 1'b0;
    bus.stop_i        = 1'b0;
    bus.instr_ready_i = 1'b0;
  endtask

  task automatic step(input bit lv, input logic [DW-1:0] ld, input bit clr,
                      input bit st, input bit md, input bit sp, input bit rdy);
    int            cur;
    logic [DW-1:0] w;
    bit            started;
    bus.load_valid_i  = lv;
    bus.load_data_i   = ld;
    bus.load_clear_i  = clr;
    bus.start_i       = st;
    bus.mode_i        = md;
    bus.stop_i        = sp;
    bus.instr_ready_i = rdy;
    m_done = 1'b0;
    if (m_run) begin
      cur = m_pc();
      w   = m_prog[cur];
      if (rdy) begin
        $display("[TB] xfer pc=%0d instr=%08h", cur, w);
        m_n++;
        if ((w[3:0] == 4'hF) || sp || (!m_mode && (m_n == m_run_cnt))) begin
          m_run = 1'b0; m_hold_pc = cur; m_done = 1'b1;
        end
      end else if (sp) begin
        m_run = 1'b0; m_hold_pc = cur; m_done = 1'b1;
      end
    end else if (clr) begin
      m_cnt = 0;
    end else begin
      started = st && (m_cnt > 0);
      if (lv && (m_cnt < DEPTH)) begin
        m_prog[m_cnt] = ld;
        m_cnt++;
      end
      if (started) begin
        m_run = 1'b1; m_n = 0; m_mode = md; m_run_cnt = m_cnt;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_cycle(input bit rdy);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic load_word(input logic [DW-1:0] w);
    step(1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_store();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_run(input bit md);
    step(1'b0, '0, 1'b0, 1'b1, md, 1'b0, 1'b1);
  endtask

  // Raise reset between edges and expect the outputs to drop without waiting for a clock.
  task automatic async_reset();
    drive_idle();
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_busy",  64'(bus.busy_o),        64'd0);
    check_eq("arst_valid", 64'(bus.instr_valid_o), 64'd0);
    check_eq("arst_pc",    64'(bus.pc_o),          64'd0);
    check_eq("arst_count", 64'(bus.count_o),       64'd0);
    check_eq("arst_instr", 64'(bus.instr_o),       64'd0);
    check_eq("arst_done",  64'(bus.done_o),        64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic [DW-1:0] d;
    bit            lv, clr, st, md, sp, rdy;
    for (int i = 0; i < DEPTH; i++) m_prog[i] = '0;
    model_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    idle_cycle(1'b0);

    // Single pass, consumer always ready.
    load_word(32'h0000_0113);
    load_word(32'h0000_0161);
    load_word(32'h0000_0272);
    start_run(1'b0);
    repeat (4) idle_cycle(1'b1);

    // Same program with consumer back-pressure.
    start_run(1'b0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Loop mode: three full passes, then stop.
    start_run(1'b1);
    repeat (9) idle_cycle(1'b1);
    check_eq("loops_after9", 64'(bus.loops_o), 64'd3);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycle(1'b1);

    // HALT in the middle of a looping program.
    clear_store();
    load_word(32'h0000_0011);
    load_word(32'h0000_000F);
    load_word(32'h0000_0022);
    start_run(1'b1);
    repeat (4) idle_cycle(1'b1);

    // Overfill, clear, then start on an empty store.
    clear_store();
    for (int i = 0; i < DEPTH + 2; i++) load_word($urandom & 32'hFFFF_FFF0);
    check_eq("count_full", 64'(bus.count_o), 64'(DEPTH));
    clear_store();
    start_run(1'b0);
    idle_cycle(1'b1);

    // Asynchronous reset mid-run.
    load_word(32'h0000_0113);
    load_word(32'h0000_0161);
    load_word(32'h0000_0272);
    start_run(1'b0);
    idle_cycle(1'b1);
    async_reset();
    idle_cycle(1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        d = $urandom;
        if ($urandom_range(0, 9) == 0) d[3:0] = 4'hF;
        else if (d[3:0] == 4'hF) d[3:0] = 4'h0;
        lv  = $urandom_range(0, 1) == 1;
        clr = $urandom_range(0, 29) == 0;
        st  = $urandom_range(0, 7) == 0;
        md  = $urandom_range(0, 1) == 1;
        sp  = $urandom_range(0, 24) == 0;
        rdy = $urandom_range(0, 3) != 0;
        step(lv, d, clr, st, md, sp, rdy);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/instr_player.md
INSTR_PLAYER -- requirements
Module: instr_player

Interface
REQ-001 Parameter DATAWIDTH, default 32: instruction word width; SHALL be >= 4.
REQ-002 Parameter DEPTH, default 16: program store capacity in words; SHALL be a power of two >= 2.
REQ-003 Parameter HALT_OP, default 4'hF: opcode field value (instr[3:0]) that ends playback.
REQ-004 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 load_valid_i  in  1  program word offered.
REQ-007 load_data_i  in  DATAWIDTH  program word.
REQ-008 load_ready_o  out  1  store accepts a word this cycle.
REQ-009 load_clear_i  in  1  empty the program store (IDLE only).
REQ-010 start_i  in  1  begin playback (level sampled in IDLE).
REQ-011 mode_i  in  1  0 = single pass, 1 = loop; sampled when start is accepted.
REQ-012 stop_i  in  1  abort playback.
REQ-013 instr_o  out  DATAWIDTH  current instruction to the core.
REQ-014 instr_valid_o  out  1  instr_o is valid.
REQ-015 instr_ready_i  in  1  core accepts instr_o.
REQ-016 busy_o  out  1  high in RUN.
REQ-017 done_o  out  1  one-cycle pulse on every RUN->IDLE transition.
REQ-018 count_o  out  $clog2(DEPTH)+1  number of loaded words.
REQ-019 pc_o  out  $clog2(DEPTH)  index of instruction presented.
REQ-020 loops_o  out  16  completed loop passes since last start; wraps at 2^16.

Function
REQ-021 Two states: IDLE, RUN; busy_o SHALL equal (state == RUN).
REQ-022 Load handshake: load_ready_o = IDLE && count < DEPTH; word transfers when load_valid_i && load_ready_o, written to mem[count], count += 1.
REQ-023 Full store: count == DEPTH -> load_ready_o = 0, further words not accepted, store unchanged.
REQ-024 load_clear_i in IDLE: count <- 0 next cycle; clear wins over a simultaneous load transfer (word discarded); memory contents unchanged; ignored in RUN.
REQ-025 start_i in IDLE with count > 0 (and no load_clear_i): RUN next cycle, pc <- 0, loops <- 0, mode latched; start_i with count == 0 ignored, no done_o.
REQ-026 Start and load transfer in the same IDLE cycle: word stored and counted, playback includes it.
REQ-027 RUN: instr_valid_o = 1, instr_o = mem[pc]; first instruction valid the cycle after start accepted (latency 1).
REQ-028 While instr_valid_o && !instr_ready_i, instr_o and pc_o SHALL hold stable.
REQ-029 Transfer in RUN with instr_o[3:0] == HALT_OP: the HALT word counts as delivered; IDLE next cycle, done_o pulses, regardless of mode.
REQ-030 Transfer with pc == count-1 (not HALT): mode 0 -> IDLE, done_o pulse; mode 1 -> pc <- 0, loops += 1, stay RUN.
REQ-031 Other transfers: pc += 1.
REQ-032 stop_i in RUN: IDLE next cycle, done_o pulse; a transfer in the same cycle completes (counts as delivered), pc not advanced further; stop_i in IDLE ignored.
REQ-033 In IDLE instr_valid_o = 0 and instr_o = 0; pc_o holds last value until next start.
REQ-034 done_o SHALL be high exactly one cycle per RUN->IDLE transition, never in IDLE otherwise.
REQ-035 Load inputs ignored in RUN (load_ready_o = 0).

Reset
REQ-036 rst_i high SHALL immediately force: state IDLE, count_o 0, pc_o 0, loops_o 0, instr_valid_o 0, instr_o 0, done_o 0, busy_o 0; load_ready_o 1 once state is IDLE.
REQ-037 Reset asserted mid-RUN SHALL abort with no done_o pulse; memory contents not reset and not required valid.

Verification
REQ-038 Load 32'h0000_0113, 32'h0000_0161, 32'h0000_0272, mode 0, start, ready=1 -> three words on consecutive cycles, pc 0,1,2, done_o pulse cycle after third, count_o = 3.
REQ-039 Same program, ready toggled 1,0,0,1,1 -> instr_o held during ready=0, exactly three transfers, order preserved.
REQ-040 Load 3 words, mode 1, ready=1 for 9 cycles, then stop_i -> sequence 0,1,2 repeated, loops_o = 3 after 9th transfer, done_o on stop.
REQ-041 Load 32'h0000_0011, 32'h0000_000F, 32'h0000_0022, mode 1 -> two transfers, HALT delivered, IDLE with done_o, third word never presented.
REQ-042 Offer DEPTH+2 words -> count_o = DEPTH, load_ready_o = 0 after DEPTH; load_clear_i -> count_o = 0; start with empty store -> no RUN, no done_o.
REQ-043 Assert rst_i asynchronously mid-RUN between edges -> instr_valid_o, busy_o, pc_o, count_o zero immediately, no done_o.
